scoreboard_display: RTL and testbench

Display-side consumer of the scoreboard up/down counter value. It takes the binary count (0-99 range), converts it to two BCD digits with a sequential shift-add-3 converter, and drives a time-multiplexed two-digit common seven-segment display. It sits between the counter output and the chip's output pins.

---
 rtl/scoreboard_pkg.sv | 49 ++++
 rtl/bin2bcd_seq.sv | 86 ++++++++
 rtl/scoreboard_display.sv | 109 ++++++++++
 tb/tb_scoreboard_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared constants for the scoreboard display slice: segment patterns,
// digit-select codes, converter state type and a BCD-to-segment decoder.
package scoreboard_pkg;

   // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // One-hot digit enables
   localparam logic [1:0] DIG_ONES = 2'b01;
   localparam logic [1:0] DIG_TENS = 2'b10;

   // Sequential binary-to-BCD converter states
   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   // Map one BCD digit to its segment pattern; non-decimal codes go dark
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock.
// A start pulse in IDLE captures the value; BW steps later the result is
// presented in DONE for exactly one cycle.
module bin2bcd_seq
   import scoreboard_pkg::*;
#(
   parameter int BW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [BW-1:0] value,
   output logic          busy,
   output logic          done,
   output logic [3:0]    tens,
   output logic [3:0]    ones
);

   // Three BCD nibbles sit above the binary field so values up to 999 fit
   localparam int SW = BW + 12;
   localparam int CW = $clog2(BW + 1);

   conv_state_t   state, state_nxt;
   logic [SW-1:0] shreg, shreg_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   // One double-dabble step: add 3 to every nibble >= 5, then shift left
   function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
      logic [SW-1:0] t;
      t = s;
      for (int n = 0; n < 3; n++) begin
         if (t[BW+4*n +: 4] >= 4'd5) begin
            t[BW+4*n +: 4] = t[BW+4*n +: 4] + 4'd3;
         end
      end
      return {t[SW-2:0], 1'b0};
   endfunction

   // State, shift register and step counter; reset aborts any conversion
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: load on start, step BW times, then one DONE cycle
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               shreg_nxt = {{12{1'b0}}, value};
               cnt_nxt   = CW'(BW);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            shreg_nxt = dabble(shreg);
            cnt_nxt   = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign ones = shreg[BW+3:BW];
   assign tens = shreg[BW+7:BW+4];

endmodule

// File: rtl/scoreboard_display.sv
// Two-digit multiplexed seven-segment driver for the scoreboard count.
// Detects a change in the binary count, converts it to BCD with
// bin2bcd_seq, latches the result atomically and scans the two digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module scoreboard_display
   import scoreboard_pkg::*;
#(
   parameter int BW          = 7,
   parameter int REFRESH_DIV = 1000,
   parameter int MAX_VAL     = 99
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [BW-1:0] counter_val_i,
   output logic [6:0]    seg_o,
   output logic [1:0]    digit_sel_o,
   output logic          busy_o
);

   localparam int RW = $clog2(REFRESH_DIV);

   logic          conv_busy;
   logic          conv_done;
   logic [3:0]    conv_tens;
   logic [3:0]    conv_ones;
   logic          start;

   logic [BW-1:0] last_val;
   logic          ov_pend;
   logic [3:0]    tens_disp;
   logic [3:0]    ones_disp;
   logic          ov_disp;

   logic [RW-1:0] refresh_cnt;
   logic          wrap;
   logic [1:0]    sel_nxt;
   logic [6:0]    seg_nxt;

   // A new conversion only starts while the converter is idle
   assign start  = !conv_busy && (counter_val_i != last_val);
   assign busy_o = conv_busy;

   bin2bcd_seq #(
      .BW (BW)
   ) u_conv (
      .clk   (clk_i),
      .rst   (rst_i),
      .start (start),
      .value (counter_val_i),
      .busy  (conv_busy),
      .done  (conv_done),
      .tens  (conv_tens),
      .ones  (conv_ones)
   );

   // Remember what is being converted and publish results only when complete
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_val  <= '0;
         ov_pend   <= 1'b0;
         tens_disp <= 4'd0;
         ones_disp <= 4'd0;
         ov_disp   <= 1'b0;
      end else begin
         if (start) begin
            last_val <= counter_val_i;
            ov_pend  <= (int'(counter_val_i) > MAX_VAL);
         end
         if (conv_done) begin
            tens_disp <= conv_tens;
            ones_disp <= conv_ones;
            ov_disp   <= ov_pend;
         end
      end
   end

   // Pick the next digit and its pattern so select and segments move together
   always_comb begin
      wrap    = (refresh_cnt == RW'(REFRESH_DIV - 1));
      sel_nxt = digit_sel_o;
      if (wrap) begin
         sel_nxt = (digit_sel_o == DIG_ONES) ? DIG_TENS : DIG_ONES;
      end
      seg_nxt = seg_decode(ones_disp);
      if (ov_disp) begin
         seg_nxt = SEG_DASH;
      end else if (sel_nxt == DIG_TENS) begin
`ifdef LEADING_ZERO_BLANK_EN
         seg_nxt = (tens_disp == 4'd0) ? SEG_BLANK : seg_decode(tens_disp);
`else
         seg_nxt = seg_decode(tens_disp);
`endif
      end
   end

   // Refresh counter and registered display outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         refresh_cnt <= '0;
         digit_sel_o <= DIG_ONES;
         seg_o       <= SEG_0;
      end else begin
         refresh_cnt <= wrap ? '0 : refresh_cnt + RW'(1);
         digit_sel_o <= sel_nxt;
         seg_o       <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_scoreboard_display.sv
// Testbench for scoreboard_display with a behavioural reference model.
// Honours LEADING_ZERO_BLANK_EN the same way as the design.
module tb_scoreboard_display;

   localparam int BW   = 7;
   localparam int DIV  = 4;
   localparam int MAXV = 99;

   localparam logic [6:0] SEG_TABLE [10] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
   };
   localparam logic [6:0] DASH = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] TENS_ZERO = 7'b0000000;
`else
   localparam logic [6:0] TENS_ZERO = 7'b0111111;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [BW-1:0] counter_val_i = '0;
   logic [6:0]    seg_o;
   logic [1:0]    digit_sel_o;
   logic          busy_o;

   int vectors     = 0;
   int miscompares = 0;

   scoreboard_display #(
      .BW          (BW),
      .REFRESH_DIV (DIV),
      .MAX_VAL     (MAXV)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .counter_val_i (counter_val_i),
      .seg_o         (seg_o),
      .digit_sel_o   (digit_sel_o),
      .busy_o        (busy_o)
   );

   // Free-running clock, period 10
   always #5 clk_i = ~clk_i;

   // Safety net so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Pattern a digit position must show for a given displayed number
   function automatic logic [6:0] expectSeg(input bit tens, input int v);
      if (v > MAXV) return DASH;
      if (tens) begin
`ifdef LEADING_ZERO_BLANK_EN
         if (v < 10) return 7'b0000000;
`endif
         return SEG_TABLE[(v / 10) % 10];
      end
      return SEG_TABLE[v % 10];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: a changed value becomes visible BW+1 edges after it
   // is noticed, the digit scan flips every DIV edges counted from reset
   bit         model_on = 1'b0;
   int         m_cycles, m_shown, m_last, m_pend, m_rem;
   logic [6:0] exp_seg;
   logic [1:0] exp_sel;
   logic       exp_busy;

   always @(posedge clk_i) begin
      bit tens_now;
      if (rst_i) begin
         model_on = 1'b1;
         m_cycles = 0;
         m_shown  = 0;
         m_last   = 0;
         m_pend   = 0;
         m_rem    = 0;
         exp_seg  = expectSeg(1'b0, 0);
      end else if (model_on) begin
         m_cycles++;
         tens_now = ((m_cycles / DIV) % 2) == 1;
         exp_seg  = expectSeg(tens_now, m_shown);
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_shown = m_pend;
         end else if (int'(counter_val_i) != m_last) begin
            m_last = int'(counter_val_i);
            m_pend = int'(counter_val_i);
            m_rem  = BW + 1;
         end
      end
      tens_now = ((m_cycles / DIV) % 2) == 1;
      exp_sel  = tens_now ? 2'b10 : 2'b01;
      exp_busy = (m_rem > 0);
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk_i) begin
      if (model_on) begin
         checkOutput("seg", 32'(seg_o), 32'(exp_seg));
         checkOutput("digit_sel", 32'(digit_sel_o), 32'(exp_sel));
         checkOutput("busy", 32'(busy_o), 32'(exp_busy));
      end
   end

   task automatic applyStimulus(input int val, input int ncycles);
      @(posedge clk_i);
      #1 counter_val_i = BW'(val);
      repeat (ncycles) @(posedge clk_i);
   endtask

   // Wait (bounded) for a digit to be selected and check its literal pattern
   task automatic checkDigit(input string name, input logic [1:0] sel, input logic [6:0] expv);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 2 * DIV + 2 && !found; i++) begin
         @(negedge clk_i);
         if (digit_sel_o === sel) begin
            found = 1'b1;
            checkOutput(name, 32'(seg_o), 32'(expv));
         end
      end
      if (!found) checkOutput({name, "_select_timeout"}, 32'(digit_sel_o), 32'(sel));
   endtask

   initial begin
      rst_i = 1'b1;
      counter_val_i = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("reset_seg", 32'(seg_o), 32'(7'b0111111));
      checkOutput("reset_sel", 32'(digit_sel_o), 32'(2'b01));
      checkOutput("reset_busy", 32'(busy_o), 32'(1'b0));
      repeat (10) @(posedge clk_i);
      checkDigit("zero_tens", 2'b10, TENS_ZERO);
      checkDigit("zero_ones", 2'b01, 7'b0111111);

      applyStimulus(42, 12);
      checkDigit("v42_ones", 2'b01, 7'b1011011);
      checkDigit("v42_tens", 2'b10, 7'b1100110);

      applyStimulus(99, 12);
      checkDigit("v99_ones", 2'b01, 7'b1101111);
      checkDigit("v99_tens", 2'b10, 7'b1101111);

      applyStimulus(100, 12);
      checkDigit("v100_ones", 2'b01, DASH);
      checkDigit("v100_tens", 2'b10, DASH);

      applyStimulus(127, 12);
      checkDigit("v127_ones", 2'b01, DASH);
      checkDigit("v127_tens", 2'b10, DASH);

      applyStimulus(5, 12);
      checkDigit("v5_ones", 2'b01, 7'b1101101);
      checkDigit("v5_tens", 2'b10, TENS_ZERO);

      // Change arriving mid-conversion
      applyStimulus(0, 12);
      applyStimulus(42, 3);
      applyStimulus(57, 20);
      checkDigit("v57_ones", 2'b01, 7'b0000111);
      checkDigit("v57_tens", 2'b10, 7'b1101101);

      // Reset in the middle of a conversion
      applyStimulus(0, 12);
      applyStimulus(42, 4);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("midreset_seg", 32'(seg_o), 32'(7'b0111111));
      checkOutput("midreset_busy", 32'(busy_o), 32'(1'b0));
      rst_i = 1'b0;
      repeat (14) @(posedge clk_i);
      checkDigit("restart42_ones", 2'b01, 7'b1011011);
      checkDigit("restart42_tens", 2'b10, 7'b1100110);

      // Static value for scan checking
      applyStimulus(63, 14);
      repeat (2 * DIV) @(posedge clk_i);
      checkDigit("v63_tens", 2'b10, 7'b1111101);
      checkDigit("v63_ones", 2'b01, 7'b1001111);

      // Randomized changes with occasional reset
      for (int i = 0; i < 600; i++) begin
         @(posedge clk_i);
         #1;
         if ($urandom_range(0, 7) == 0) counter_val_i = BW'($urandom_range(0, 127));
         rst_i = ($urandom_range(0, 79) == 0);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      repeat (20) @(posedge clk_i);
      @(negedge clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
